regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Merges the two result producers of the CPU, the single-cycle pipeline writeback and the variable-latency load unit, onto the single write port of the register file (`writeEnable`, `writeSelect`, `writeData`). Load results are buffered in a small in-order FIFO while the pipeline owns the port. A starvation counter guarantees forward progress for buffered loads. Hazard flags tell the operand-read stage when a requested register still has a write in flight.

## Interface
Parameters:
- `DEPTH`, 2: load FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 4: consecutive cycles a non-empty FIFO may lose to the pipeline before it is forced through (≥1).

Ports:
- `clk`  in  1: clock, all state on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `wbValid`  in  1: pipeline result present.
- `wbSelect`  in  5: pipeline destination register.
- `wbData`  in  32: pipeline result.
- `wbStall`  out  1: pipeline result not taken this cycle; upstream holds `wb*` stable.
- `ldValid`  in  1: load result present.
- `ldSelect`  in  5: load destination register.
- `ldData`  in  32: load result.
- `ldReady`  out  1: load result accepted when `ldValid && ldReady`.
- `readASelect`, `readBSelect`  in  5: registers being read by operand stage.
- `hazardA`, `hazardB`  out  1: write to that register still pending.
- `writeEnable`  out  1: to register file.
- `writeSelect`  out  5: to register file.
- `writeData`  out  32: to register file.
- `pendingCount`  out  $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Clock `clk` and synchronous active-high `rst`, as decided.
- `ldReady` = `pendingCount < DEPTH`. It depends on registered count only, not on same-cycle pop.
- `force` = FIFO non-empty && `starveCnt == STARVE_LIMIT`.
- `wbStall` = `wbValid && force`. This is combinational.
- Per-cycle issue priority:
  1. If `force`: pop the FIFO head; the pipeline stalls.
  2. Else if `wbValid`: issue the pipeline result.
  3. Else if the FIFO is non-empty: pop the head.
  4. Else if `ldValid && ldReady`: issue the load directly (bypass, not stored).
  5. Else: no write.
- Accepted load not bypassed: pushed at the FIFO tail.
- Simultaneous push and pop: count unchanged; the head pops and the new entry lands at the tail.
- Loads retire strictly in acceptance order.
- Starvation counter `starveCnt`:
  - Increments when the FIFO is non-empty and the pipeline wins.
  - Clears on any FIFO pop, or when the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
- Hazard: `hazardA` is high if `readASelect` equals the select of any valid FIFO entry, or equals `writeSelect` while `writeEnable` = 1. `hazardB` is identical using `readBSelect`. Both are combinational and cover all 32 selects, including 0.
- Width rules: selects and data pass unmodified; no sign or zero extension.

## Timing
- `writeEnable`, `writeSelect`, `writeData` are registered. A result issued in cycle N appears on the port in cycle N+1, so the register file commits it at the end of N+1.
- Bypassed load: 1-cycle latency. Buffered load: ≥2 cycles.
- `writeEnable` is high for exactly one cycle per issued result. With back-to-back issues it stays high across consecutive cycles.
- `ldReady` is low in every cycle where `pendingCount == DEPTH`, including a cycle that also pops. The freed slot is visible the following cycle.
- Reset values:
  - Outputs: `writeEnable`=0, `writeSelect`=0, `writeData`=0, `pendingCount`=0, `starveCnt`=0, `ldReady`=1, `wbStall`=0, `hazardA`=0, `hazardB`=0.
  - FIFO entries invalidated.
- Reset mid-operation: buffered loads are discarded without being written, and any write registered in that cycle is suppressed.
- Bounded wait: with continuous `wbValid`, the FIFO head is written within `STARVE_LIMIT`+1 cycles. A full FIFO drains in at most DEPTH×(`STARVE_LIMIT`+1) cycles.

## Test plan
- Reset, then idle: every output at its reset value; `ldReady`=1, `pendingCount`=0.
- Lone pipeline write `wbSelect`=5, `wbData`=5001 in cycle N → cycle N+1 shows `writeEnable`=1, `writeSelect`=5, `writeData`=5001; cycle N+2 shows `writeEnable`=0.
- Simultaneous `wbValid`(r3, 3001) and `ldValid`(r7, 7013) with FIFO empty:
  - r3 is written first and r7 on the next cycle.
  - `pendingCount` is 1 for one cycle.
  - `hazardA`=1 while `readASelect`=7 until r7 leaves the write port.
- Continuous `wbValid`, then 3 loads (r1=1013, r2=2013, r3=3013) with DEPTH=2:
  - `ldReady` drops after 2 accepted; the third load is held.
  - After 4 pipeline wins, `wbStall`=1 for one cycle and r1 is written.
  - Loads are written in order r1, r2, r3.
- FIFO full with simultaneous pop and new `ldValid`: `ldReady`=0 that cycle; the load is accepted the next cycle; `pendingCount` never exceeds 2.
- `rst` asserted with 2 buffered loads: neither load is ever written, `pendingCount`=0 the next cycle, and no `writeEnable` pulse follows.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Merges the single-cycle pipeline writeback and the variable-latency load unit onto one
// registered write port. Load results that lose arbitration wait in a small in-order FIFO.
// A starvation counter forces the FIFO head through after a bounded number of lost cycles.
// Hazard flags report registers that still have a write in flight.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,

  // Pipeline writeback
  input  logic                     wbValid,
  input  logic [4:0]               wbSelect,
  input  logic [31:0]              wbData,
  output logic                     wbStall,

  // Load unit
  input  logic                     ldValid,
  input  logic [4:0]               ldSelect,
  input  logic [31:0]              ldData,
  output logic                     ldReady,

  // Operand-read hazard query
  input  logic [4:0]               readASelect,
  input  logic [4:0]               readBSelect,
  output logic                     hazardA,
  output logic                     hazardB,

  // Register-file write port
  output logic                     writeEnable,
  output logic [4:0]               writeSelect,
  output logic [31:0]              writeData,

  output logic [$clog2(DEPTH):0]   pendingCount
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CntW-1:0]    DepthCnt  = CntW'(DEPTH);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  // FIFO storage; entryValidQ tracks which slots hold a not-yet-issued load.
  logic [4:0]         fifoSel  [DEPTH];
  logic [31:0]        fifoData [DEPTH];
  logic [DEPTH-1:0]   entryValidQ, entryValidD;
  logic [PtrW-1:0]    headQ, headD;
  logic [PtrW-1:0]    tailQ, tailD;
  logic [CntW-1:0]    countQ, countD;
  logic [StarveW-1:0] starveCntQ, starveCntD;

  // Arbitration results for the current cycle
  logic        fifoEmpty;
  logic        forceDrain;
  logic        ldAccept;
  logic        push;
  logic        pop;
  logic        bypass;
  logic        issueValid;
  logic [4:0]  issueSel;
  logic [31:0] issueData;

  assign fifoEmpty    = (countQ == '0);
  // Readiness looks only at the registered count, so a slot freed by a pop this cycle is
  // offered next cycle.
  assign ldReady      = (countQ < DepthCnt);
  assign forceDrain   = !fifoEmpty && (starveCntQ == StarveMax);
  assign wbStall      = wbValid && forceDrain;
  assign ldAccept     = ldValid && ldReady;
  assign pendingCount = countQ;

  // Pick this cycle's write source in priority order.
  always_comb begin
    pop        = 1'b0;
    bypass     = 1'b0;
    issueValid = 1'b0;
    issueSel   = '0;
    issueData  = '0;
    if (forceDrain) begin
      pop        = 1'b1;
      issueValid = 1'b1;
      issueSel   = fifoSel[headQ];
      issueData  = fifoData[headQ];
    end else if (wbValid) begin
      issueValid = 1'b1;
      issueSel   = wbSelect;
      issueData  = wbData;
    end else if (!fifoEmpty) begin
      pop        = 1'b1;
      issueValid = 1'b1;
      issueSel   = fifoSel[headQ];
      issueData  = fifoData[headQ];
    end else if (ldAccept) begin
      // Nothing older is waiting, so the load skips the FIFO entirely.
      bypass     = 1'b1;
      issueValid = 1'b1;
      issueSel   = ldSelect;
      issueData  = ldData;
    end
    push = ldAccept && !bypass;
  end

  // Compute FIFO pointer, occupancy, valid-bit and starvation-counter updates.
  always_comb begin
    headD       = headQ;
    tailD       = tailQ;
    countD      = countQ;
    entryValidD = entryValidQ;
    starveCntD  = starveCntQ;

    if (pop) begin
      headD              = headQ + PtrW'(1);
      entryValidD[headQ] = 1'b0;
    end
    if (push) begin
      tailD              = tailQ + PtrW'(1);
      entryValidD[tailQ] = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   countD = countQ + CntW'(1);
      2'b01:   countD = countQ - CntW'(1);
      default: countD = countQ;
    endcase

    // A waiting FIFO that did not pop this cycle lost to the pipeline.
    if (fifoEmpty || pop) begin
      starveCntD = '0;
    end else if (starveCntQ != StarveMax) begin
      starveCntD = starveCntQ + StarveW'(1);
    end
  end

  // Control state and the registered write port; reset discards buffered loads and
  // suppresses any write issued in the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      headQ       <= '0;
      tailQ       <= '0;
      countQ      <= '0;
      entryValidQ <= '0;
      starveCntQ  <= '0;
      writeEnable <= 1'b0;
      writeSelect <= '0;
      writeData   <= '0;
    end else begin
      headQ       <= headD;
      tailQ       <= tailD;
      countQ      <= countD;
      entryValidQ <= entryValidD;
      starveCntQ  <= starveCntD;
      writeEnable <= issueValid;
      writeSelect <= issueSel;
      writeData   <= issueData;
    end
  end

  // FIFO payload; contents are only meaningful where entryValidQ is set.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoSel[tailQ]  <= ldSelect;
      fifoData[tailQ] <= ldData;
    end
  end

  // Flag operand reads that target a register with a buffered or in-flight write.
  always_comb begin
    hazardA = writeEnable && (writeSelect == readASelect);
    hazardB = writeEnable && (writeSelect == readBSelect);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (entryValidQ[i] && (fifoSel[i] == readASelect)) hazardA = 1'b1;
      if (entryValidQ[i] && (fifoSel[i] == readBSelect)) hazardB = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter (DEPTH=2, STARVE_LIMIT=4).
// Each task drives one scenario and pushes the writes it expects, in write order, onto a
// scoreboard queue; a monitor pops and compares every writeEnable pulse.
module tb_regfile_write_arbiter;

  localparam int unsigned DEPTH        = 2;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned CW           = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0]  sel;
    logic [31:0] data;
  } wrRecT;

  logic          clk = 1'b0;
  logic          rst;
  logic          wbValid;
  logic [4:0]    wbSelect;
  logic [31:0]   wbData;
  logic          wbStall;
  logic          ldValid;
  logic [4:0]    ldSelect;
  logic [31:0]   ldData;
  logic          ldReady;
  logic [4:0]    readASelect;
  logic [4:0]    readBSelect;
  logic          hazardA;
  logic          hazardB;
  logic          writeEnable;
  logic [4:0]    writeSelect;
  logic [31:0]   writeData;
  logic [CW-1:0] pendingCount;

  int    vectors     = 0;
  int    miscompares = 0;
  wrRecT expQ[$];

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wbValid     (wbValid),
    .wbSelect    (wbSelect),
    .wbData      (wbData),
    .wbStall     (wbStall),
    .ldValid     (ldValid),
    .ldSelect    (ldSelect),
    .ldData      (ldData),
    .ldReady     (ldReady),
    .readASelect (readASelect),
    .readBSelect (readBSelect),
    .hazardA     (hazardA),
    .hazardB     (hazardB),
    .writeEnable (writeEnable),
    .writeSelect (writeSelect),
    .writeData   (writeData),
    .pendingCount(pendingCount)
  );

  // Scoreboard: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    wrRecT expRec;
    if (writeEnable !== 1'b0) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got we=%b r%0d=%h, required no write",
                 writeEnable, writeSelect, writeData);
      end else begin
        expRec = expQ.pop_front();
        if (writeEnable !== 1'b1 || writeSelect !== expRec.sel || writeData !== expRec.data) begin
          miscompares++;
          $display("FAIL write_order: got we=%b r%0d=%h, required r%0d=%h",
                   writeEnable, writeSelect, writeData, expRec.sel, expRec.data);
        end
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] obs [8];
    logic [31:0] req [8];
    string       nm  [8];
    nm  = '{"writeEnable", "writeSelect", "writeData", "pendingCount",
            "ldReady", "wbStall", "hazardA", "hazardB"};
    req = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0};
    repeat (2) nextCycle();
    rst = 1'b0;
    repeat (2) nextCycle();
    @(negedge clk);
    obs = '{32'(writeEnable), 32'(writeSelect), writeData, 32'(pendingCount),
            32'(ldReady), 32'(wbStall), 32'(hazardA), 32'(hazardB)};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (obs[i] !== req[i]) begin
        miscompares++;
        $display("FAIL reset_%s: got %h, required %h", nm[i], obs[i], req[i]);
      end
    end
  endtask

  task automatic test_lone_wb();
    nextCycle();
    wbValid  = 1'b1;
    wbSelect = 5'd5;
    wbData   = 32'd5001;
    expQ.push_back('{5'd5, 32'd5001});
    @(negedge clk);
    vectors++;
    if (wbStall !== 1'b0) begin
      miscompares++;
      $display("FAIL lone_wbStall: got %b, required 0", wbStall);
    end
    nextCycle();
    wbValid = 1'b0;
    @(negedge clk);
    vectors++;
    if (writeEnable !== 1'b1 || writeSelect !== 5'd5 || writeData !== 32'd5001) begin
      miscompares++;
      $display("FAIL lone_latency: got we=%b r%0d=%0d, required we=1 r5=5001",
               writeEnable, writeSelect, writeData);
    end
    nextCycle();
    @(negedge clk);
    vectors++;
    if (writeEnable !== 1'b0) begin
      miscompares++;
      $display("FAIL lone_pulse: got we=%b, required 0", writeEnable);
    end
  endtask

  task automatic test_simultaneous();
    nextCycle();
    wbValid     = 1'b1;
    wbSelect    = 5'd3;
    wbData      = 32'd3001;
    ldValid     = 1'b1;
    ldSelect    = 5'd7;
    ldData      = 32'd7013;
    readASelect = 5'd7;
    expQ.push_back('{5'd3, 32'd3001});
    expQ.push_back('{5'd7, 32'd7013});
    @(negedge clk);
    vectors++;
    if (ldReady !== 1'b1 || wbStall !== 1'b0 || hazardA !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_issue: got ldReady=%b wbStall=%b hazardA=%b, required 1 0 0",
               ldReady, wbStall, hazardA);
    end
    nextCycle();
    wbValid = 1'b0;
    ldValid = 1'b0;
    @(negedge clk);
    vectors++;
    if (writeSelect !== 5'd3 || pendingCount !== CW'(1) || hazardA !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_buffered: got r%0d count=%0d hazardA=%b, required r3 1 1",
               writeSelect, pendingCount, hazardA);
    end
    nextCycle();
    @(negedge clk);
    vectors++;
    if (writeSelect !== 5'd7 || pendingCount !== CW'(0) || hazardA !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_inflight: got r%0d count=%0d hazardA=%b, required r7 0 1",
               writeSelect, pendingCount, hazardA);
    end
    nextCycle();
    @(negedge clk);
    vectors++;
    if (writeEnable !== 1'b0 || hazardA !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_retired: got we=%b hazardA=%b, required 0 0", writeEnable, hazardA);
    end
  endtask

  task automatic test_bypass();
    nextCycle();
    ldValid     = 1'b1;
    ldSelect    = 5'd0;
    ldData      = 32'hFFFF_0000;
    readBSelect = 5'd0;
    expQ.push_back('{5'd0, 32'hFFFF_0000});
    @(negedge clk);
    vectors++;
    if (ldReady !== 1'b1 || hazardB !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_accept: got ldReady=%b hazardB=%b, required 1 0", ldReady, hazardB);
    end
    nextCycle();
    ldValid = 1'b0;
    @(negedge clk);
    vectors++;
    if (writeEnable !== 1'b1 || pendingCount !== CW'(0) || hazardB !== 1'b1) begin
      miscompares++;
      $display("FAIL bypass_write: got we=%b count=%0d hazardB=%b, required 1 0 1",
               writeEnable, pendingCount, hazardB);
    end
    nextCycle();
    @(negedge clk);
    vectors++;
    if (hazardB !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_clear: got hazardB=%b, required 0", hazardB);
    end
  endtask

  // Continuous pipeline traffic; three loads force their way through one at a time.
  task automatic test_starvation();
    logic [15:0]   stallVec = 16'h8420;
    logic [15:0]   readyVec = 16'hF843;
    logic [CW-1:0] cntTab [16];
    int            wi       = 0;
    int            li       = 0;
    int            pi       = 0;
    cntTab = '{0, 1, 2, 2, 2, 2, 1, 2, 2, 2, 2, 1, 1, 1, 1, 1};
    for (int c = 0; c < 16; c++) begin
      nextCycle();
      wbValid  = 1'b1;
      wbSelect = 5'd20;
      wbData   = 32'd9000 + 32'(wi);
      ldValid  = (li < 3);
      ldSelect = 5'(li + 1);
      ldData   = 32'((li + 1) * 1000 + 13);
      if (stallVec[c]) begin
        expQ.push_back('{5'(pi + 1), 32'((pi + 1) * 1000 + 13)});
        pi++;
      end else begin
        expQ.push_back('{5'd20, 32'd9000 + 32'(wi)});
      end
      @(negedge clk);
      vectors++;
      if (wbStall !== stallVec[c] || ldReady !== readyVec[c] || pendingCount !== cntTab[c]) begin
        miscompares++;
        $display("FAIL starve_c%0d: got wbStall=%b ldReady=%b count=%0d, required %b %b %0d",
                 c, wbStall, ldReady, pendingCount, stallVec[c], readyVec[c], cntTab[c]);
      end
      if (!stallVec[c]) wi++;
      if (readyVec[c] && li < 3) li++;
    end
    nextCycle();
    wbValid = 1'b0;
    ldValid = 1'b0;
    nextCycle();
    @(negedge clk);
    vectors++;
    if (pendingCount !== CW'(0) || writeEnable !== 1'b0) begin
      miscompares++;
      $display("FAIL starve_drained: got count=%0d we=%b, required 0 0", pendingCount, writeEnable);
    end
  endtask

  // Full FIFO pops while a new load waits: the load is refused that cycle, taken the next.
  task automatic test_full_pop_push();
    logic          wbV  [6];
    logic          ldV  [6];
    logic [4:0]    ldS  [6];
    logic          rdy  [6];
    logic [CW-1:0] cnt  [6];
    wbV = '{1, 1, 0, 0, 0, 0};
    ldV = '{1, 1, 1, 1, 0, 0};
    ldS = '{5'd11, 5'd12, 5'd13, 5'd13, 5'd0, 5'd0};
    rdy = '{1, 1, 0, 1, 1, 1};
    cnt = '{0, 1, 2, 1, 1, 0};
    expQ.push_back('{5'd21, 32'd2100});
    expQ.push_back('{5'd21, 32'd2101});
    expQ.push_back('{5'd11, 32'd1101});
    expQ.push_back('{5'd12, 32'd1202});
    expQ.push_back('{5'd13, 32'd1303});
    for (int c = 0; c < 6; c++) begin
      nextCycle();
      wbValid  = wbV[c];
      wbSelect = 5'd21;
      wbData   = 32'd2100 + 32'(c);
      ldValid  = ldV[c];
      ldSelect = ldS[c];
      ldData   = 32'(ldS[c]) * 32'd100 + 32'(ldS[c] - 5'd10);
      @(negedge clk);
      vectors++;
      if (ldReady !== rdy[c] || pendingCount !== cnt[c] || pendingCount > CW'(DEPTH)) begin
        miscompares++;
        $display("FAIL fullpop_c%0d: got ldReady=%b count=%0d, required %b %0d",
                 c, ldReady, pendingCount, rdy[c], cnt[c]);
      end
    end
    ldValid = 1'b0;
    nextCycle();
  endtask

  // Reset with two buffered loads: neither may ever reach the write port.
  task automatic test_reset_mid();
    nextCycle();
    wbValid  = 1'b1;
    wbSelect = 5'd22;
    wbData   = 32'd2200;
    ldValid  = 1'b1;
    ldSelect = 5'd14;
    ldData   = 32'd1404;
    expQ.push_back('{5'd22, 32'd2200});
    nextCycle();
    wbData   = 32'd2201;
    ldSelect = 5'd15;
    ldData   = 32'd1505;
    expQ.push_back('{5'd22, 32'd2201});
    nextCycle();
    wbValid = 1'b0;
    ldValid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    vectors++;
    if (pendingCount !== CW'(2)) begin
      miscompares++;
      $display("FAIL rstmid_full: got count=%0d, required 2", pendingCount);
    end
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (pendingCount !== CW'(0) || writeEnable !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_cleared: got count=%0d we=%b, required 0 0", pendingCount, writeEnable);
    end
    for (int c = 0; c < 4; c++) begin
      nextCycle();
      @(negedge clk);
      vectors++;
      if (writeEnable !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_nowrite_c%0d: got we=%b, required 0", c, writeEnable);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    wbValid     = 1'b0;
    wbSelect    = '0;
    wbData      = '0;
    ldValid     = 1'b0;
    ldSelect    = '0;
    ldData      = '0;
    readASelect = '0;
    readBSelect = '0;

    test_reset();
    test_lone_wb();
    test_simultaneous();
    test_bypass();
    test_starvation();
    test_full_pop_push();
    test_reset_mid();

    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d writes missing, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
